// File: rtl/hsynth_playback_apb.sv
// hsynth_playback_apb: APB slave packing 32-bit writes into 64-bit stereo frames in a FIFO popped by the I2S side.
//  Ports: clk, reset_n (async active-low); APB paddr/psel/penable/pwrite/pwdata -> prdata/pready;
//  playback_fifo_data/playback_fifo_empty/i2s_playback_enable to I2S, i2s_playback_fifo_ack pop strobe (async);
//  playback_dma_req/playback_dma_single/playback_dma_ack DMA handshake; irq only with HSYNTH_PLAYBACK_IRQ_EN.
module hsynth_playback_apb #(
  parameter int DEPTH_LOG2 = 4,
  parameter int THR_RESET  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic [63:0] playback_fifo_data,
  input  logic        i2s_playback_fifo_ack,
  output logic        playback_fifo_empty,
  output logic        i2s_playback_enable,
  output logic        playback_dma_req,
  output logic        playback_dma_single,
`ifdef HSYNTH_PLAYBACK_IRQ_EN
  output logic        irq,
`endif
  input  logic        playback_dma_ack
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int UW = DEPTH_LOG2 + 1;
  logic [63:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0] used;
  logic [31:0] left, sts, sts_nxt, rd_mux;
  logic [15:0] undr_cnt;
  logic [4:0] thr;
  logic [2:0] s;
  logic phase, ovf, undr, dma_en, play_en, fifo_clr_p, sticky_clr_p;
  logic ie_undr, ie_low, irq_q;
  logic setup, wr_acc, data_wr, cmd_wr, thr_wr, push_req, full, empty, pop, push_ok, pop_ok, below_thr;
  assign setup     = psel & ~penable & ~pwrite;
  assign wr_acc    = psel & penable & pwrite;
  assign data_wr   = wr_acc & (paddr == 5'h00);
  assign cmd_wr    = wr_acc & (paddr == 5'h08);
  assign thr_wr    = wr_acc & (paddr == 5'h0C);
  assign push_req  = data_wr & phase;
  assign full      = used == UW'(DEPTH);
  assign empty     = used == '0;
  // falling edge of the synchronised ack: one pop per I2S pulse
  assign pop       = s[2] & ~s[1];
  assign push_ok   = push_req & ~full & ~fifo_clr_p;
  assign pop_ok    = pop & ~empty & ~fifo_clr_p;
  assign below_thr = 32'(used) < 32'(thr);
  assign pready    = penable;
  assign playback_fifo_empty = empty;
  assign playback_fifo_data  = empty ? 64'h0 : mem[rd_ptr];
  assign i2s_playback_enable = play_en & ~empty;
  assign sts_nxt = {10'd0, irq_q, play_en, playback_dma_ack, playback_dma_req, playback_dma_single, dma_en,
                    3'd0, 5'(used), 3'd0, undr, ovf, phase, full, empty};
  // pulse bits of CMD always read back as 0
  assign rd_mux = paddr == 5'h04 ? sts :
                  paddr == 5'h08 ? {24'd0, ie_low, ie_undr, 3'd0, play_en, dma_en, 1'b0} :
                  paddr == 5'h0C ? {27'd0, thr} :
                  paddr == 5'h10 ? {16'd0, undr_cnt} : 32'd0;
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= {pwdata, left};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      phase  <= 1'b0;
      left   <= 32'd0;
    end else if (fifo_clr_p) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      phase  <= 1'b0;
    end else begin
      if (data_wr) phase <= ~phase;
      if (data_wr & ~phase) left <= pwdata;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      used <= used + UW'(push_ok) - UW'(pop_ok);
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ovf      <= 1'b0;
      undr     <= 1'b0;
      undr_cnt <= 16'd0;
    end else if (sticky_clr_p) begin
      ovf      <= 1'b0;
      undr     <= 1'b0;
      undr_cnt <= 16'd0;
    end else begin
      if (push_req & full) ovf <= 1'b1;
      if (pop & empty) begin
        undr     <= 1'b1;
        undr_cnt <= &undr_cnt ? undr_cnt : undr_cnt + 16'd1;
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prdata              <= 32'd0;
      dma_en              <= 1'b0;
      play_en             <= 1'b0;
      fifo_clr_p          <= 1'b0;
      sticky_clr_p        <= 1'b0;
      thr                 <= 5'(THR_RESET);
      s                   <= 3'd0;
      playback_dma_req    <= 1'b0;
      playback_dma_single <= 1'b0;
      sts                 <= 32'd0;
    end else begin
      fifo_clr_p   <= cmd_wr & pwdata[0];
      sticky_clr_p <= cmd_wr & pwdata[5];
      if (cmd_wr) begin
        dma_en  <= pwdata[1];
        play_en <= pwdata[2];
      end
      if (thr_wr) thr <= pwdata[4:0];
      if (setup) prdata <= rd_mux;
      s <= {s[1:0], i2s_playback_fifo_ack};
      // no burst request while a frame is half written
      playback_dma_req    <= ~playback_dma_ack & dma_en & below_thr & ~phase;
      playback_dma_single <= ~playback_dma_ack & dma_en & ~full;
      sts <= sts_nxt;
    end
`ifdef HSYNTH_PLAYBACK_IRQ_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ie_undr <= 1'b0;
      ie_low  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (cmd_wr) begin
        ie_undr <= pwdata[6];
        ie_low  <= pwdata[7];
      end
      irq_q <= (ie_undr & undr) | (ie_low & below_thr);
    end
  assign irq = irq_q;
`else
  assign ie_undr = 1'b0;
  assign ie_low  = 1'b0;
  assign irq_q   = 1'b0;
`endif
endmodule

// File: tb/tb_hsynth_playback_apb.sv
// tb_hsynth_playback_apb: self-checking bench for hsynth_playback_apb (register table plus FIFO/DMA/underrun sequences).
module tb_hsynth_playback_apb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [4:0] paddr = 5'd0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic pready;
  logic [63:0] playback_fifo_data;
  logic ack = 1'b0, dma_ack = 1'b0;
  logic empty, enable, dma_req, dma_single;
`ifdef HSYNTH_PLAYBACK_IRQ_EN
  logic irq;
`endif
  int n_chk = 0, n_fail = 0;
  logic [63:0] sb[$];
  logic [31:0] rd;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  hsynth_playback_apb dut (
    .clk(clk), .reset_n(reset_n), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .playback_fifo_data(playback_fifo_data),
    .i2s_playback_fifo_ack(ack), .playback_fifo_empty(empty), .i2s_playback_enable(enable),
    .playback_dma_req(dma_req), .playback_dma_single(dma_single),
`ifdef HSYNTH_PLAYBACK_IRQ_EN
    .irq(irq),
`endif
    .playback_dma_ack(dma_ack));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    apb_rd(a, v);
    chk(nm, {32'd0, v}, {32'd0, exp});
  endtask

  task automatic wr_frame(input logic [31:0] l, input logic [31:0] r);
    apb_wr(5'h00, l);
    apb_wr(5'h00, r);
    sb.push_back({r, l});
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'h08, 32'h06, 32'h06};
`ifdef HSYNTH_PLAYBACK_IRQ_EN
    vecs[1] = '{5'h08, 32'hC0, 32'hC0};
`else
    vecs[1] = '{5'h08, 32'hC0, 32'h00};
`endif
    vecs[2] = '{5'h0C, 32'h1F, 32'h1F};
    vecs[3] = '{5'h0C, 32'h25, 32'h05};
    vecs[4] = '{5'h0C, 32'h08, 32'h08};
    vecs[5] = '{5'h08, 32'h21, 32'h00};
    vecs[6] = '{5'h08, 32'h00, 32'h00};
    repeat (3) @(posedge clk);
    #1;
    chk("reset prdata", {32'd0, prdata}, 64'd0);
    chk("reset empty", {63'd0, empty}, 64'd1);
    chk("reset data", playback_fifo_data, 64'd0);
    chk("reset dma_req", {63'd0, dma_req}, 64'd0);
    chk("reset dma_single", {63'd0, dma_single}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("reset THR", 5'h0C, 32'd8);
    rd_chk("reset CMD", 5'h08, 32'd0);
    rd_chk("reset UNDR", 5'h10, 32'd0);
    rd_chk("reset DATA read", 5'h00, 32'd0);
    for (int i = 0; i < 7; i++) begin
      apb_wr(vecs[i].addr, vecs[i].wdata);
      apb_rd(vecs[i].addr, rd);
      chk($sformatf("reg vec %0d", i), {32'd0, rd}, {32'd0, vecs[i].exp});
    end
    rd_chk("idle STS", 5'h04, 32'h1);
    chk("pready", {63'd0, pready}, 64'd0);
    wr_frame(32'h11111111, 32'h22222222);
    chk("first frame data", playback_fifo_data, 64'h22222222_11111111);
    chk("first frame empty", {63'd0, empty}, 64'd0);
    rd_chk("first frame STS", 5'h04, 32'h100);
    for (int i = 1; i < 16; i++) wr_frame(32'hA0000000 + i, 32'hB0000000 + i);
    apb_wr(5'h00, 32'hDEAD0001);
    apb_wr(5'h00, 32'hDEAD0002);
    rd_chk("full STS", 5'h04, 32'h100A);
    chk("full head", playback_fifo_data, 64'h22222222_11111111);
    apb_wr(5'h08, 32'h01);
    sb.delete();
    rd_chk("clr keeps ovf", 5'h04, 32'h9);
    apb_wr(5'h08, 32'h20);
    rd_chk("sticky_clr STS", 5'h04, 32'h1);
    apb_wr(5'h08, 32'h04);
    for (int i = 0; i < 3; i++) wr_frame(32'hC0000000 + i, 32'hD0000000 + i);
    chk("play enable", {63'd0, enable}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (sb.size() > 0) chk($sformatf("pop head %0d", i), playback_fifo_data, sb.pop_front());
      else chk("empty head", playback_fifo_data, 64'd0);
      ack_pulse();
    end
    chk("underrun data", playback_fifo_data, 64'd0);
    chk("underrun enable", {63'd0, enable}, 64'd0);
    rd_chk("underrun STS", 5'h04, 32'h00100011);
    rd_chk("underrun UNDR", 5'h10, 32'd1);
    apb_wr(5'h08, 32'h02);
    for (int i = 0; i < 7; i++) wr_frame(32'hE0000000 + i, 32'hF0000000 + i);
    chk("dma req used7", {63'd0, dma_req}, 64'd1);
    chk("dma single used7", {63'd0, dma_single}, 64'd1);
    dma_ack = 1'b1;
    @(posedge clk); #1;
    chk("dma req acked", {63'd0, dma_req}, 64'd0);
    chk("dma single acked", {63'd0, dma_single}, 64'd0);
    dma_ack = 1'b0;
    wr_frame(32'hE0000007, 32'hF0000007);
    chk("dma req used8", {63'd0, dma_req}, 64'd0);
    chk("dma single used8", {63'd0, dma_single}, 64'd1);
    apb_wr(5'h08, 32'h01);
    sb.delete();
    for (int i = 0; i < 5; i++) wr_frame(32'h90000000 + i, 32'h91000000 + i);
    rd_chk("used5 STS", 5'h04, 32'h510);
    apb_wr(5'h00, 32'h5A5A0001);
    ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ack = 1'b0;
    apb_wr(5'h00, 32'h5A5A0002);
    void'(sb.pop_front());
    sb.push_back(64'h5A5A0002_5A5A0001);
    rd_chk("push+pop STS", 5'h04, 32'h510);
    chk("push+pop head", playback_fifo_data, sb[0]);
    apb_wr(5'h00, 32'h77777777);
    apb_wr(5'h08, 32'h01);
    sb.delete();
    rd_chk("clr half STS", 5'h04, 32'h11);
    rd_chk("clr keeps UNDR", 5'h10, 32'd1);
    chk("clr data", playback_fifo_data, 64'd0);
`ifdef HSYNTH_PLAYBACK_IRQ_EN
    apb_wr(5'h08, 32'h20);
    apb_wr(5'h08, 32'h40);
    chk("irq idle", {63'd0, irq}, 64'd0);
    ack_pulse();
    chk("irq underrun", {63'd0, irq}, 64'd1);
    rd_chk("irq STS bit", 5'h04, 32'h00200011);
    apb_wr(5'h08, 32'h60);
    chk("irq cleared", {63'd0, irq}, 64'd0);
    apb_wr(5'h08, 32'h00);
`endif
    wr_frame(32'h12340001, 32'h12340002);
    apb_wr(5'h00, 32'hCAFE0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset empty", {63'd0, empty}, 64'd1);
    chk("async reset data", playback_fifo_data, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    wr_frame(32'hBEEF0001, 32'hBEEF0002);
    chk("post-reset frame", playback_fifo_data, sb.pop_front());
    rd_chk("post-reset UNDR", 5'h10, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
